// File: rtl/stack_pace_controller.sv
// Stacker game sequencer: engine reset, move-tick pacing that speeds up per completed line,
// drop edge strobes, line counting and win/lose latching. All outputs are registered.
module stack_pace_controller #(
  parameter int BASE_PERIOD   = 24,
  parameter int STEP          = 2,
  parameter int MIN_PERIOD    = 6,
  parameter int NUM_LINES     = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rstBtn,
  input  logic       startBtn,
  input  logic       dropBtn,
  input  logic       EOG,
  output logic       timer,
  output logic       dropPulse,
  output logic       engineRst,
  output logic [3:0] lineCount,
  output logic       gameOver,
  output logic       gameWon
);

  localparam int PW = CNT_W + 4;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_PLAY,
    S_SETTLE,
    S_LOSE,
    S_WIN
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic             eog_seen_q, eog_seen_d;
  logic [3:0]       line_q, line_d;
  logic [3:0]       line_inc;
  logic             start_prev_q, drop_prev_q;
  logic             timer_q, timer_d;
  logic             drop_pulse_q, drop_pulse_d;
  logic             engine_rst_q, engine_rst_d;
  logic             game_over_q, game_over_d;
  logic             game_won_q, game_won_d;
  logic             start_edge, drop_edge;

  // Returns period(n)-1, clamped to the floor without wrapping when n*STEP exceeds the base.
  function automatic logic [CNT_W-1:0] period_m1(input logic [3:0] n);
    logic [PW-1:0] dec;
    logic [PW-1:0] base;
    logic [PW-1:0] minp;
    logic [PW-1:0] p;
    dec  = PW'(n) * PW'(STEP);
    base = PW'(BASE_PERIOD);
    minp = PW'(MIN_PERIOD);
    if ((dec >= base) || ((base - dec) < minp)) begin
      p = minp;
    end else begin
      p = base - dec;
    end
    return CNT_W'(p - PW'(1));
  endfunction

  assign start_edge = startBtn & ~start_prev_q;
  assign drop_edge  = dropBtn & ~drop_prev_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    settle_d     = settle_q;
    eog_seen_d   = eog_seen_q;
    line_d       = line_q;
    timer_d      = 1'b0;
    drop_pulse_d = 1'b0;
    line_inc     = (line_q >= 4'(NUM_LINES)) ? 4'(NUM_LINES) : line_q + 4'd1;

    case (state_q)
      S_IDLE, S_LOSE, S_WIN: begin
        if (start_edge) begin
          state_d = S_ARM;
          line_d  = '0;
        end
      end
      S_ARM: begin
        cnt_d   = period_m1(4'd0);
        state_d = S_PLAY;
      end
      S_PLAY: begin
        if (drop_edge) begin
          drop_pulse_d = 1'b1;
          settle_d     = SW'(SETTLE_CYCLES - 1);
          eog_seen_d   = 1'b0;
          state_d      = S_SETTLE;
        end else if (EOG) begin
          state_d = S_LOSE;
        end else begin
          cnt_d = (cnt_q == '0) ? period_m1(line_q) : cnt_q - CNT_W'(1);
          // Registered tick lands in the cycle where the counter reads zero.
          timer_d = (cnt_d == '0);
        end
      end
      S_SETTLE: begin
        eog_seen_d = eog_seen_q | EOG;
        if (settle_q == '0) begin
          if (eog_seen_q | EOG) begin
            state_d = S_LOSE;
          end else begin
            line_d = line_inc;
            if (line_inc == 4'(NUM_LINES)) begin
              state_d = S_WIN;
            end else begin
              cnt_d   = period_m1(line_inc);
              timer_d = (cnt_d == '0);
              state_d = S_PLAY;
            end
          end
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Engine stays out of reset in LOSE/WIN so its display freezes on the final board.
    engine_rst_d = (state_d != S_IDLE) && (state_d != S_ARM);
    game_over_d  = (state_d == S_LOSE);
    game_won_d   = (state_d == S_WIN);
  end

  always_ff @(posedge clk) begin
    if (!rstBtn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      settle_q     <= '0;
      eog_seen_q   <= 1'b0;
      line_q       <= '0;
      start_prev_q <= 1'b0;
      drop_prev_q  <= 1'b0;
      timer_q      <= 1'b0;
      drop_pulse_q <= 1'b0;
      engine_rst_q <= 1'b0;
      game_over_q  <= 1'b0;
      game_won_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      settle_q     <= settle_d;
      eog_seen_q   <= eog_seen_d;
      line_q       <= line_d;
      start_prev_q <= startBtn;
      drop_prev_q  <= dropBtn;
      timer_q      <= timer_d;
      drop_pulse_q <= drop_pulse_d;
      engine_rst_q <= engine_rst_d;
      game_over_q  <= game_over_d;
      game_won_q   <= game_won_d;
    end
  end

  assign timer     = timer_q;
  assign dropPulse = drop_pulse_q;
  assign engineRst = engine_rst_q;
  assign lineCount = line_q;
  assign gameOver  = game_over_q;
  assign gameWon   = game_won_q;

endmodule

// File: tb/tb_stack_pace_controller.sv
// Directed bench for stack_pace_controller: default-parameter instance plus a fast-floor instance.
module tb_stack_pace_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstBtn, startBtn, dropBtn, EOG;
  logic startBtn2, dropBtn2, eog2;
  logic timer, dropPulse, engineRst, gameOver, gameWon;
  logic [3:0] lineCount;
  logic timer2, dropPulse2, engineRst2, gameOver2, gameWon2;
  logic [3:0] lineCount2;

  int n_checks = 0;
  int n_fail = 0;
  int sel = 0;

  stack_pace_controller dut (
    .clk(clk), .rstBtn(rstBtn), .startBtn(startBtn), .dropBtn(dropBtn), .EOG(EOG),
    .timer(timer), .dropPulse(dropPulse), .engineRst(engineRst),
    .lineCount(lineCount), .gameOver(gameOver), .gameWon(gameWon)
  );

  stack_pace_controller #(.BASE_PERIOD(10), .STEP(3), .MIN_PERIOD(6)) dut2 (
    .clk(clk), .rstBtn(rstBtn), .startBtn(startBtn2), .dropBtn(dropBtn2), .EOG(eog2),
    .timer(timer2), .dropPulse(dropPulse2), .engineRst(engineRst2),
    .lineCount(lineCount2), .gameOver(gameOver2), .gameWon(gameWon2)
  );

  typedef struct {
    logic  rst;
    logic  start;
    logic  drop;
    logic  eog;
    int    n;
    logic  timer;
    logic  dpulse;
    logic  erst;
    int    lines;
    logic  over;
    logic  won;
    string nm;
  } vec_t;

  vec_t tbl[10];

  int p1[8] = '{24, 22, 20, 18, 16, 14, 12, 10};
  int p2[4] = '{10, 7, 6, 6};

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int o_timer();  return sel != 0 ? int'(timer2)     : int'(timer);     endfunction
  function automatic int o_dp();     return sel != 0 ? int'(dropPulse2) : int'(dropPulse); endfunction
  function automatic int o_erst();   return sel != 0 ? int'(engineRst2) : int'(engineRst); endfunction
  function automatic int o_lines();  return sel != 0 ? int'(lineCount2) : int'(lineCount); endfunction

  task automatic set_drop(input logic v);
    if (sel != 0) dropBtn2 = v; else dropBtn = v;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Starts just before the first PLAY cycle; counts PLAY cycles up to the first tick.
  task automatic measure_tick(input int exp_p, input int exp_line, input string nm);
    int k;
    k = 0;
    do begin
      step();
      k++;
      if (k == 1) chk({nm, " lineCount"}, o_lines(), exp_line);
      chk({nm, " no dropPulse"}, o_dp(), 0);
    end while (o_timer() == 0 && k < 200);
    chk({nm, " period"}, k, exp_p);
  endtask

  // Called at a tick cycle; returns at the last SETTLE cycle.
  task automatic do_drop(input string nm);
    set_drop(1'b1);
    step();
    chk({nm, " dropPulse"}, o_dp(), 1);
    chk({nm, " timer during pulse"}, o_timer(), 0);
    set_drop(1'b0);
    repeat (3) begin
      step();
      chk({nm, " settle timer"}, o_timer(), 0);
      chk({nm, " settle dropPulse"}, o_dp(), 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int dp_cnt;
    int t_cnt;
    int t_first;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, "reset values"};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, "ARM, start+drop"};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, "PLAY 1"};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 21, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, "PLAY 22"};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, "PLAY 23"};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, "tick 24"};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, "PLAY 25"};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 23, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, "tick 48"};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, "start in PLAY"};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 23, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, "tick 72"};

    rstBtn = 1'b0; startBtn = 1'b0; dropBtn = 1'b0; EOG = 1'b0;
    startBtn2 = 1'b0; dropBtn2 = 1'b0; eog2 = 1'b0;
    step();

    for (int i = 0; i < 10; i++) begin
      rstBtn = tbl[i].rst; startBtn = tbl[i].start; dropBtn = tbl[i].drop; EOG = tbl[i].eog;
      for (int j = 1; j <= tbl[i].n; j++) begin
        step();
        if (j < tbl[i].n) begin
          chk({tbl[i].nm, " idle timer"}, int'(timer), 0);
          chk({tbl[i].nm, " idle dropPulse"}, int'(dropPulse), 0);
        end
      end
      chk({tbl[i].nm, " timer"}, int'(timer), int'(tbl[i].timer));
      chk({tbl[i].nm, " dropPulse"}, int'(dropPulse), int'(tbl[i].dpulse));
      chk({tbl[i].nm, " engineRst"}, int'(engineRst), int'(tbl[i].erst));
      chk({tbl[i].nm, " lineCount"}, int'(lineCount), tbl[i].lines);
      chk({tbl[i].nm, " gameOver"}, int'(gameOver), int'(tbl[i].over));
      chk({tbl[i].nm, " gameWon"}, int'(gameWon), int'(tbl[i].won));
    end

    // Drop edge on the cycle before the counter reads zero, then held for 50 cycles.
    repeat (23) begin
      step();
      chk("pre-coincident timer", int'(timer), 0);
    end
    dropBtn = 1'b1;
    dp_cnt = 0; t_cnt = 0; t_first = 0;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (i == 1) begin
        chk("coincident dropPulse", int'(dropPulse), 1);
        chk("coincident timer", int'(timer), 0);
      end
      if (dropPulse) dp_cnt++;
      if (timer) begin
        t_cnt++;
        if (t_first == 0) t_first = i;
      end
    end
    dropBtn = 1'b0;
    chk("held drop pulse count", dp_cnt, 1);
    chk("first tick after settle", t_first, 26);
    chk("ticks in held window", t_cnt, 2);
    chk("lineCount after first drop", int'(lineCount), 1);

    // Clean drops through to the win.
    measure_tick(20, 1, "line1 third tick");
    for (int n = 2; n < 8; n++) begin
      do_drop("climb drop");
      measure_tick(p1[n], n, "climb");
    end
    do_drop("winning drop");
    step();
    chk("win gameWon", int'(gameWon), 1);
    chk("win lineCount", int'(lineCount), 8);
    chk("win engineRst", int'(engineRst), 1);
    chk("win gameOver", int'(gameOver), 0);
    t_cnt = 0; dp_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      dropBtn = i[2];
      step();
      if (timer) t_cnt++;
      if (dropPulse) dp_cnt++;
    end
    dropBtn = 1'b0;
    chk("timer in WIN", t_cnt, 0);
    chk("dropPulse in WIN", dp_cnt, 0);
    chk("WIN held", int'(gameWon), 1);
    startBtn = 1'b1;
    step();
    startBtn = 1'b0;
    chk("restart lineCount", int'(lineCount), 0);
    chk("restart gameWon", int'(gameWon), 0);
    chk("restart engineRst", int'(engineRst), 0);

    // EOG mid-settle on line 3.
    measure_tick(24, 0, "replay line0");
    for (int n = 1; n < 4; n++) begin
      do_drop("replay drop");
      measure_tick(p1[n], n, "replay");
    end
    dropBtn = 1'b1;
    step();
    chk("lose dropPulse", int'(dropPulse), 1);
    step();
    EOG = 1'b1;
    step();
    EOG = 1'b0;
    dropBtn = 1'b0;
    step();
    chk("settle not yet lost", int'(gameOver), 0);
    step();
    chk("LOSE gameOver", int'(gameOver), 1);
    chk("LOSE lineCount", int'(lineCount), 3);
    chk("LOSE engineRst", int'(engineRst), 1);
    chk("LOSE gameWon", int'(gameWon), 0);
    dp_cnt = 0; t_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      dropBtn = i[1];
      step();
      if (dropPulse) dp_cnt++;
      if (timer) t_cnt++;
    end
    dropBtn = 1'b0;
    chk("dropPulse in LOSE", dp_cnt, 0);
    chk("timer in LOSE", t_cnt, 0);
    chk("LOSE held", int'(gameOver), 1);

    // Restart from LOSE, then EOG directly in PLAY.
    startBtn = 1'b1;
    step();
    startBtn = 1'b0;
    chk("ARM clears gameOver", int'(gameOver), 0);
    chk("ARM clears lineCount", int'(lineCount), 0);
    repeat (3) step();
    chk("PLAY engineRst", int'(engineRst), 1);
    EOG = 1'b1;
    step();
    EOG = 1'b0;
    chk("EOG in PLAY loses", int'(gameOver), 1);

    // Fast-floor instance: periods clamp instead of wrapping, then mid-PLAY reset.
    sel = 1;
    startBtn2 = 1'b1;
    step();
    startBtn2 = 1'b0;
    chk("dut2 ARM engineRst", int'(engineRst2), 0);
    measure_tick(p2[0], 0, "dut2 line0");
    for (int n = 1; n < 4; n++) begin
      do_drop("dut2 drop");
      measure_tick(p2[n], n, "dut2");
    end
    repeat (2) step();
    chk("dut2 pre-reset engineRst", int'(engineRst2), 1);
    rstBtn = 1'b0;
    step();
    rstBtn = 1'b1;
    chk("dut2 reset timer", int'(timer2), 0);
    chk("dut2 reset dropPulse", int'(dropPulse2), 0);
    chk("dut2 reset engineRst", int'(engineRst2), 0);
    chk("dut2 reset lineCount", int'(lineCount2), 0);
    chk("dut2 reset gameOver", int'(gameOver2), 0);
    chk("dut2 reset gameWon", int'(gameWon2), 0);
    chk("dut1 reset gameOver", int'(gameOver), 0);
    t_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (timer2) t_cnt++;
    end
    chk("dut2 idle after reset timer", t_cnt, 0);
    chk("dut2 idle after reset engineRst", int'(engineRst2), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_pace_controller.md
Name: stack_pace_controller

Overview:
Sequencer for the stacker game engine. It holds the engine in reset until start and generates the engine's single-cycle `timer` move ticks, with a period that shrinks as lines are completed. It converts the raw drop button into one-cycle drop pulses, counts completed lines and latches win/lose. It sits between board inputs and the game engine; its `engineRst` drives the engine's `rstBtn`.

Parameters:
- BASE_PERIOD, 24: clocks between move ticks on line 0.
- STEP, 2: period reduction per completed line.
- MIN_PERIOD, 6: floor on the tick period.
- NUM_LINES, 8: completed lines needed to win.
- SETTLE_CYCLES, 4: cycles after a drop during which the engine updates; ticks and drops are ignored.
- CNT_W, 16: tick counter width.

Ports:
- clk, in, 1: system clock.
- rstBtn, in, 1: synchronous, active-low reset.
- startBtn, in, 1: level input, already synchronized; the rising edge starts or restarts a game.
- dropBtn, in, 1: level input, already synchronized and debounced; the rising edge requests a drop.
- EOG, in, 1: end-of-game flag from the engine (missed stack).
- timer, out, 1: one-cycle move tick to the engine.
- dropPulse, out, 1: one-cycle drop strobe to the engine.
- engineRst, out, 1: active-low engine reset.
- lineCount, out, 4: completed lines, 0..NUM_LINES.
- gameOver, out, 1: lose flag, held.
- gameWon, out, 1: win flag, held.

Behaviour:
- All outputs are registered. Reset acts when rstBtn=0 at a clk edge, from any state including mid-game.
- Reset values: state=IDLE, timer=0, dropPulse=0, engineRst=0, lineCount=0, gameOver=0, gameWon=0, tick counter=0, startPrev=0, dropPrev=0.
- Edge detection: startPrev and dropPrev update every cycle in every state.
  - startEdge = startBtn & ~startPrev; dropEdge = dropBtn & ~dropPrev.
  - A held button gives exactly one edge.
- period(n) = max(BASE_PERIOD − n·STEP, MIN_PERIOD). Compute in CNT_W+4 bits; no underflow wrap when n·STEP > BASE_PERIOD.
- States:
  - IDLE: engineRst=0. On startEdge → ARM.
  - ARM (1 cycle): engineRst=0; clear lineCount, gameOver, gameWon; load counter with period(0)−1 → PLAY.
  - PLAY: engineRst=1.
    - Counter decrements each cycle. At count 0: timer=1 that cycle, reload period(lineCount)−1.
    - First tick is in the BASE_PERIOD-th PLAY cycle; subsequent ticks every period cycles.
    - dropEdge: dropPulse=1 that cycle, timer forced 0 (drop beats a coincident tick), settle counter loaded → SETTLE.
    - EOG=1 (with no dropEdge) → LOSE.
  - SETTLE (SETTLE_CYCLES cycles): timer=0, dropEdge ignored, EOG sampled into a sticky flag. At the final cycle:
    - flag or EOG → LOSE.
    - else lineCount+1; if the new count == NUM_LINES → WIN.
    - else reload counter with period(new count)−1 → PLAY.
  - LOSE: gameOver=1, engineRst stays 1 (display frozen), timer=0. startEdge → ARM.
  - WIN: gameWon=1, otherwise as LOSE. startEdge → ARM.
- startEdge in PLAY/SETTLE is ignored. startEdge and dropEdge in the same IDLE cycle: start only, no dropPulse.
- dropPulse and timer are never high in the same cycle.
- lineCount saturates at NUM_LINES.

Test Plan:
1. Reset, then startBtn 0→1 → engineRst low one more cycle (ARM), then high. timer pulses for 1 cycle at PLAY cycles 24, 48, 72. No dropPulse.
2. In PLAY, dropBtn held high 50 cycles → exactly one dropPulse. No timer for 4 cycles. lineCount=1. Next tick 22 cycles after re-entering PLAY.
3. Drop edge on the same cycle the counter hits 0 → dropPulse=1, timer=0 that cycle, SETTLE entered.
4. Eight clean drops with EOG=0 → period sequence 24, 22, 20, 18, 16, 14, 12, 10. lineCount=8, gameWon=1, timer stays 0. startEdge → ARM, lineCount=0, gameWon=0.
5. EOG=1 during cycle 2 of SETTLE on line 3 → LOSE at settle end, gameOver=1, lineCount stays 3. Further drops give no dropPulse.
6. With BASE_PERIOD=10, STEP=3, MIN_PERIOD=6 → periods 10, 7, 6, 6 (no wrap). rstBtn=0 for one cycle mid-PLAY → next cycle all reset values, state IDLE.
